// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory access sequencer (load format, byte/half RMW); optional DMEM_MISALIGN_TRAP_EN
module dmem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_err_o,
  output logic [31:0]       resp_rdata_o,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_waddr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  typedef enum logic [2:0] {IDLE, LD_RD, LD_FMT, ST_RD, ST_WR, RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               resp_err_q, resp_err_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic [31:0]        load_fmt;
  logic [31:0]        store_word;
  logic               req_legal;
  logic               req_misalign;
  logic               req_err;

  // Bits above the RAM index are dropped on capture: the address space wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

  // Store funct3 is legal only for SB/SH/SW; loads reject 011/110/111.
  assign req_legal = req_we_i ? (!req_funct3_i[2] && req_funct3_i[1:0] != 2'b11)
                              : (req_funct3_i[1:0] != 2'b11 && !(req_funct3_i[2] && req_funct3_i[1]));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_misalign = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                        (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
  assign req_misalign = 1'b0;
`endif

  assign req_err = !req_legal || req_misalign;

  // State and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Lane select and sign/zero extension of the RAM word for loads.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = ram_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_fmt = {24'h0, lane_b};
      3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_fmt = {16'h0, lane_h};
      default: load_fmt = ram_rdata_i;
    endcase
  end

  // Store word: SW writes wdata as is; SB/SH merge into the word just read.
  always_comb begin
    store_word = ram_rdata_i;
    case (funct3_q[1:0])
      2'b00: store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      default: store_word = wdata_q;
    endcase
  end

  // Next-state and state-decoded outputs; RAM strobes never see req_* directly.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d         = req_we_i;
          funct3_d     = req_funct3_i;
          addr_d       = req_addr_i[ADDR_W+1:0];
          wdata_d      = req_wdata_i;
          resp_err_d   = req_err;
          resp_rdata_d = 32'h0;
          if (req_err)                         state_d = RESP;
          else if (!req_we_i)                  state_d = LD_RD;
          else if (req_funct3_i[1:0] == 2'b10) state_d = ST_WR;
          else                                 state_d = ST_RD;
        end
      end
      LD_RD: begin
        ram_en_o = 1'b1;
        state_d  = LD_FMT;
      end
      LD_FMT: begin
        resp_rdata_d = load_fmt;
        state_d      = RESP;
      end
      ST_RD: begin
        ram_en_o = 1'b1;
        state_d  = ST_WR;
      end
      ST_WR: begin
        ram_we_o = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign ram_raddr_o  = addr_q[ADDR_W+1:2];
  assign ram_waddr_o  = addr_q[ADDR_W+1:2];
  assign ram_wdata_o  = store_word;

  // we_q is kept for completeness of the captured request; decode uses state.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - bench for dmem_access_ctrl with RAM and byte-level memory model
module tb_dmem_access_ctrl;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int errors = 0;
  int checks = 0;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_err_o   (resp_err),
    .resp_rdata_o (resp_rdata),
    .ram_en_o     (ram_en),
    .ram_raddr_o  (ram_raddr),
    .ram_we_o     (ram_we),
    .ram_waddr_o  (ram_waddr),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port block RAM with 1-cycle synchronous read.
  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 32'h0;
    end else begin
      if (ram_en) ram_rdata <= ram[ram_raddr];
      if (ram_we) ram[ram_waddr] <= ram_wdata;
    end
  end

  // Reference memory: plain little-endian byte array over the wrapped byte space.
  logic [7:0] mref [0:(4<<ADDR_W)-1];

  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    if (we) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (!bad && (a % acc_size(f3)) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic int base_of(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = acc_size(f3);
    return (int'(a) % (4 << ADDR_W) + (4 << ADDR_W)) % (4 << ADDR_W) / n * n;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int n, b;
    logic [31:0] v;
    n = acc_size(f3);
    b = base_of(f3, a);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mref[b + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n, b;
    n = acc_size(f3);
    b = base_of(f3, a);
    for (int i = 0; i < n; i++) mref[b + i] = 8'(d >> (8 * i));
  endtask

  function automatic int model_lat(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (model_err(we, f3, a)) return 1;
    if (!we) return 3;
    return (acc_size(f3) == 4) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One transaction, entered and left at a negedge in IDLE.
  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int lat, n_en, n_we, exp_en, exp_we;
    lat = 0; n_en = 0; n_we = 0;
    exp_en = (exp_err || (we && acc_size(f3) == 4)) ? 0 : 1;
    exp_we = (!exp_err && we) ? 1 : 0;
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ram_en) n_en++;
      if (ram_we) n_we++;
      if (ram_en && ram_we) n_en = n_en + 100;
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    if (lat != 0) begin
      chk({nm, " err"}, 32'(resp_err), 32'(exp_err));
      chk({nm, " rdata"}, resp_rdata, exp_rd);
    end
    chk({nm, " ram_en cycles"}, 32'(n_en), 32'(exp_en));
    chk({nm, " ram_we cycles"}, 32'(n_we), 32'(exp_we));
    if (!exp_err && we) model_store(f3, a, d);
    @(negedge clk);
    chk({nm, " resp drop"}, 32'(resp_valid), 32'd0);
    chk({nm, " rdata hold"}, resp_rdata, exp_rd);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic we, e;
    logic [2:0] f3;
    logic [31:0] a, d;

    tv.push_back('{1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         2});
    tv.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 3});
    tv.push_back('{1'b1, 3'd0, 32'h0000_0012, 32'h1234_5655, 1'b0, 32'h0,         3});
    tv.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'hDE55_BEEF, 3});
    tv.push_back('{1'b0, 3'd0, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_0055, 3});
    tv.push_back('{1'b0, 3'd0, 32'h0000_0013, 32'h0,         1'b0, 32'hFFFF_FFDE, 3});
    tv.push_back('{1'b0, 3'd4, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_00DE, 3});
    tv.push_back('{1'b1, 3'd1, 32'h0000_0012, 32'hABCD_8001, 1'b0, 32'h0,         3});
    tv.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h8001_BEEF, 3});
    tv.push_back('{1'b0, 3'd1, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_8001, 3});
    tv.push_back('{1'b0, 3'd5, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_8001, 3});
    tv.push_back('{1'b0, 3'd3, 32'h0000_0010, 32'h0,         1'b1, 32'h0,         1});
    tv.push_back('{1'b1, 3'd4, 32'h0000_0010, 32'h1111_1111, 1'b1, 32'h0,         1});
`ifdef DMEM_MISALIGN_TRAP_EN
    tv.push_back('{1'b0, 3'd2, 32'h0000_0011, 32'h0,         1'b1, 32'h0,         1});
`else
    tv.push_back('{1'b0, 3'd2, 32'h0000_0011, 32'h0,         1'b0, 32'h8001_BEEF, 3});
`endif
    tv.push_back('{1'b1, 3'd2, 32'hFFFF_F010, 32'h1234_5678, 1'b0, 32'h0,         2});
    tv.push_back('{1'b0, 3'd2, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 3});
    tv.push_back('{1'b0, 3'd4, 32'h0000_1013, 32'h0,         1'b0, 32'h0000_0012, 3});
    tv.push_back('{1'b1, 3'd1, 32'h0000_0016, 32'h0000_BEEF, 1'b0, 32'h0,         3});
    tv.push_back('{1'b0, 3'd1, 32'h0000_0016, 32'h0,         1'b0, 32'hFFFF_BEEF, 3});
    tv.push_back('{1'b0, 3'd2, 32'h0000_0014, 32'h0,         1'b0, 32'hBEEF_0000, 3});

    for (int i = 0; i < (4 << ADDR_W); i++) mref[i] = 8'h0;
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset ram_en", 32'(ram_en), 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    rst_n = 1'b1; mem_clr = 1'b0;

    foreach (tv[i])
      do_req($sformatf("tbl%0d", i), tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata,
             tv[i].err, tv[i].rdata, tv[i].lat);

    // Held req_valid on an illegal load: re-accepted the cycle right after RESP.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd3; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk("b2b resp1 valid", 32'(resp_valid), 32'd1);
    chk("b2b resp1 err", 32'(resp_err), 32'd1);
    chk("b2b resp1 rdata", resp_rdata, 32'h0);
    chk("b2b ready in resp", 32'(req_ready), 32'd0);
    chk("b2b no ram_en", 32'(ram_en), 32'd0);
    @(negedge clk);
    chk("b2b ready after resp", 32'(req_ready), 32'd1);
    chk("b2b resp gap", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b resp2 valid", 32'(resp_valid), 32'd1);
    chk("b2b resp2 err", 32'(resp_err), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);

    // Reset during ST_WR of a byte store must drop ram_we at once and leave the word intact.
    do_req("rst pre", 1'b1, 3'd2, 32'h20, 32'h1111_1111, 1'b0, 32'h0, 2);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst st_rd ram_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    chk("rst st_wr ram_we", 32'(ram_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst ram_we drop", 32'(ram_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release ready", 32'(req_ready), 32'd1);
    chk("rst release resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    do_req("rst post", 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h1111_1111, 3);

    // Randomized traffic against the byte-level model.
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      d  = $urandom;
      e  = model_err(we, f3, a);
      do_req($sformatf("rnd%0d", i), we, f3, a, d, e,
             (e || we) ? 32'h0 : model_load(f3, a), model_lat(we, f3, a));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
